// File: rtl/star_exp_lut_pkg.sv
// Shared constants, exponent ROM contents and FSM state type for the STAR
// softmax LUT/exponent stage.
package star_exp_pkg;

  localparam int EXP_LEN_DEF = 16;
  localparam int CNT_W_DEF   = 3;
  localparam int DATA_W_DEF  = 32;
  localparam int FRAC_W      = 16;

  // Number of entries actually populated in the exponent ROM.
  localparam int TABLE_LEN   = 16;

  // round(65536 * e^(-0.5k)); every entry fits in FRAC_W+1 bits.
  localparam logic [DATA_W_DEF-1:0] EXP_TABLE [TABLE_LEN] = '{
    32'd65536, 32'd39750, 32'd24109, 32'd14623,
    32'd8869,  32'd5380,  32'd3263,  32'd1979,
    32'd1200,  32'd728,   32'd442,   32'd268,
    32'd162,   32'd99,    32'd60,    32'd36
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    READY = 2'd2
  } state_t;

endpackage

// File: rtl/star_exp_lut_onehot_enc.sv
// Priority encoder: index of the lowest set bit, plus zero and
// zero-or-multi-hot error flags.
module star_onehot_enc #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             zero,
  output logic             err
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    zero = (vec == '0);
    // vec & (vec-1) clears the lowest set bit; anything left means multi-hot.
    err  = zero | ((vec & (vec - 1'b1)) != '0);
  end

endmodule

// File: rtl/star_exp_lut.sv
// STAR softmax LUT/exponent stage: accumulates Sum_exp over the per-bin
// counts one bin per cycle, then streams exp(x_i - x_max) per element.
module star_exp_lut
  import star_exp_pkg::*;
#(
  parameter int EXP_LEN = EXP_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sum_valid,
  input  logic [EXP_LEN*CNT_W-1:0] sum_mv,
  output logic                     sum_ready,
  output logic [DATA_W-1:0]        sum_exp,
  output logic                     sum_exp_valid,
  input  logic                     sub_valid,
  input  logic [EXP_LEN-1:0]       sub_mv,
  input  logic                     sub_last,
  output logic [DATA_W-1:0]        exp,
  output logic                     exp_valid,
  output logic                     onehot_err,
  output logic                     row_done
);

  localparam int IDX_W  = $clog2(EXP_LEN);
  localparam int PROD_W = CNT_W + FRAC_W + 1;
  localparam int SUM_W  = DATA_W + 1;

  state_t                   state_reg, state_next;
  logic [IDX_W-1:0]         idx_reg;
  logic [EXP_LEN*CNT_W-1:0] counts_reg;
  logic [DATA_W-1:0]        acc_reg;
  logic [DATA_W-1:0]        sum_exp_reg;
  logic [DATA_W-1:0]        exp_reg;
  logic                     exp_valid_reg;
  logic                     err_reg;
  logic                     row_done_reg;

  logic [CNT_W-1:0]         cnt_arr [EXP_LEN];
  logic [PROD_W-1:0]        prod;
  logic [SUM_W-1:0]         acc_sum;
  logic [DATA_W-1:0]        acc_next;
  logic                     last_bin;

  logic [IDX_W-1:0]         bin;
  logic                     bin_zero;
  logic                     bin_err;

  // Unpack the latched count vector into one entry per bin.
  generate
    for (genvar gi = 0; gi < EXP_LEN; gi++) begin : g_cnt
      assign cnt_arr[gi] = counts_reg[gi*CNT_W +: CNT_W];
    end
  endgenerate

  star_onehot_enc #(
    .N     (EXP_LEN),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec  (sub_mv),
    .idx  (bin),
    .zero (bin_zero),
    .err  (bin_err)
  );

  // Multiply-accumulate for the current bin, saturating at all-ones.
  always_comb begin
    prod     = PROD_W'(cnt_arr[idx_reg]) * PROD_W'(EXP_TABLE[idx_reg][FRAC_W:0]);
    acc_sum  = {1'b0, acc_reg} + SUM_W'(prod);
    acc_next = acc_sum[DATA_W] ? '1 : acc_sum[DATA_W-1:0];
    last_bin = (idx_reg == IDX_W'(EXP_LEN - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: IDLE -> ACCUM on a new row, ACCUM -> READY after the
  // last bin, READY -> IDLE after the last element is accepted.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sum_valid) state_next = ACCUM;
      ACCUM:   if (last_bin) state_next = READY;
      READY:   if (sub_valid && sub_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: count latch, accumulator, Sum_exp and per-element exp outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_reg       <= '0;
      counts_reg    <= '0;
      acc_reg       <= '0;
      sum_exp_reg   <= '0;
      exp_reg       <= '0;
      exp_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      row_done_reg  <= 1'b0;
    end else begin
      exp_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      row_done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sum_valid) begin
            counts_reg  <= sum_mv;
            acc_reg     <= '0;
            idx_reg     <= '0;
            sum_exp_reg <= '0;
          end
        end
        ACCUM: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg + 1'b1;
          if (last_bin) sum_exp_reg <= acc_next;
        end
        READY: begin
          if (sub_valid) begin
            exp_reg       <= bin_zero ? '0 : DATA_W'(EXP_TABLE[bin]);
            exp_valid_reg <= 1'b1;
            err_reg       <= bin_err;
            row_done_reg  <= sub_last;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake levels derive from state; sum_ready stays low while in reset.
  assign sum_ready     = (state_reg == IDLE) & reset;
  assign sum_exp_valid = (state_reg == READY);
  assign sum_exp       = sum_exp_reg;
  assign exp           = exp_reg;
  assign exp_valid     = exp_valid_reg;
  assign onehot_err    = err_reg;
  assign row_done      = row_done_reg;

endmodule

// File: doc/star_exp_lut.md
Name: star_exp_lut

Overview:
- Downstream LUT/exponent stage of the STAR softmax engine.
- Accepts the per-bin occurrence counts (sum match vector) and the per-element one-hot subtraction match vectors from the STAR controller.
- Serially accumulates the softmax denominator Sum_exp, then streams exp(x_i - x_max) per element in Q16.16.
- Feeds the exp/Sum_exp division stage.

Parameters:
- EXP_LEN, 16, number of LUT bins (width of sub match vector).
- CNT_W, 3, width of each per-bin count.
- DATA_W, 32, width of exp and Sum_exp (Q16.16).

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- sum_valid  in  1  sum_mv valid; accepted only when sum_ready=1.
- sum_mv  in  EXP_LEN*CNT_W  packed counts; bin k at bits [k*CNT_W +: CNT_W].
- sum_ready  out  1  high in IDLE only.
- sum_exp  out  DATA_W  accumulated denominator, Q16.16.
- sum_exp_valid  out  1  level, high while in READY.
- sub_valid  in  1  sub_mv valid; accepted only in READY.
- sub_mv  in  EXP_LEN  one-hot bin index of (x_i - x_max).
- sub_last  in  1  qualifies the last element of the row.
- exp  out  DATA_W  EXP_TABLE[bin], Q16.16.
- exp_valid  out  1  one-cycle pulse per accepted sub_mv.
- onehot_err  out  1  pulse with exp_valid when sub_mv is not one-hot.
- row_done  out  1  pulse coincident with the exp_valid of the sub_last element.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; idx=0; accumulator=0.
  - sum_exp=0, exp=0; all valid/err/done outputs 0.
  - sum_ready=1 once reset is released.
  - Reset mid-operation aborts the row; no partial outputs are emitted.
- LUT: EXP_TABLE[k] = round(65536*e^(-0.5k)), k=0..EXP_LEN-1, constant ROM. Values include [0]=65536, [1]=39750, [2]=24109, [3]=14623.
- FSM states:
  - IDLE:
    - sum_ready=1.
    - On sum_valid, latch sum_mv, clear accumulator, idx=0, go to ACCUM.
    - sub_valid is ignored.
  - ACCUM:
    - One bin per cycle: acc += cnt[idx]*EXP_TABLE[idx]; idx++.
    - After idx=EXP_LEN-1, go to READY; sum_exp takes the final acc on the same edge.
    - Takes exactly EXP_LEN cycles; sum_valid and sub_valid are ignored.
  - READY:
    - sum_exp_valid=1 and sum_exp is held stable.
    - Each cycle with sub_valid=1 registers exp and raises exp_valid on the next cycle (latency 1). Back-to-back acceptance is allowed every cycle.
    - On accepted sub_valid with sub_last=1, go to IDLE on the next edge; row_done pulses with that exp_valid.
    - sum_valid is ignored.
- Bin selection:
  - Lowest set bit of sub_mv is the bin.
  - sub_mv=0 gives exp=0 with onehot_err=1.
  - More than one bit set gives the lowest bin with onehot_err=1.
- Arithmetic:
  - Product is CNT_W x 17 bits.
  - Accumulator is DATA_W bits and saturates at all-ones on overflow. With the default parameters overflow cannot occur: max 7*16*65536 = 7340032.
- exp holds its last value when exp_valid=0. sum_exp holds until the next sum_valid is accepted and is then cleared.

Decomposition:
- Package star_exp_pkg holds:
  - EXP_LEN, CNT_W, DATA_W defaults.
  - Q16.16 fraction width constant (16).
  - EXP_TABLE constant array.
  - State enum typedef (IDLE, ACCUM, READY).
- One natural sub-module: star_onehot_enc, a priority encoder from EXP_LEN to a log2 index plus a zero/multi-hot error flag.

Test Plan:
- sum_mv with cnt[0]=3, all others 0 -> sum_ready drops; 16 cycles later sum_exp=196608 and sum_exp_valid=1.
- cnt[0]=1, cnt[1]=2, cnt[2]=1 -> sum_exp=169145.
- In READY, sub_mv=16'h0004 -> next cycle exp=24109, exp_valid=1; then 16'h0001, 16'h0002 back-to-back -> 65536, 39750 on consecutive cycles.
- sub_mv=16'h0000 -> exp=0 with onehot_err=1; sub_mv=16'h0006 -> exp=39750 with onehot_err=1.
- sub_valid during ACCUM and sum_valid during READY -> no exp_valid and no state change; sub_valid with sub_last=1 -> row_done with exp_valid, sum_ready=1 the following cycle.
- reset pulled low at ACCUM cycle 5 -> outputs 0 immediately; after release, IDLE with sum_ready=1, and a fresh row completes correctly.
